seq_alu: RTL and testbench

Multi-cycle arithmetic/shift unit for the 8-bit single-cycle CPU datapath, sitting directly downstream of the register file. DATA1/DATA2 are driven by the register file read ports OUT1/OUT2. RESULT drives the register file write data IN, and DONE serves as the write strobe that the control unit gates onto WRITE. It adds the iterative operations the combinational ALU lacks: multiply, variable shifts and rotate, executed one bit per clock under a START/BUSY/DONE handshake.

---
 rtl/seq_alu.sv | 140 ++++++++++++++
 tb/tb_seq_alu.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Brief    : Multi-cycle 8-bit multiply / shift / rotate unit, one bit per
//             clock, START/BUSY/DONE handshake towards the register file.
//  Revision : 1.0  initial release
// ============================================================================
module seq_alu (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DATA1,
  input  logic [7:0] DATA2,
  input  logic [2:0] SELECT,
  input  logic       START,
  output logic [7:0] RESULT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ZERO,
  output logic       OVF
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_FIN  = 2'd2;

  localparam logic [2:0] c_OP_MUL = 3'b000;
  localparam logic [2:0] c_OP_SLL = 3'b001;
  localparam logic [2:0] c_OP_SRL = 3'b010;
  localparam logic [2:0] c_OP_SRA = 3'b011;
  localparam logic [2:0] c_OP_ROR = 3'b100;

  logic [1:0]  r_state;
  logic [2:0]  r_op;
  logic [3:0]  r_cnt;
  logic [7:0]  r_val;    // shift operand, or multiplier for MUL
  logic [15:0] r_mcand;
  logic [15:0] r_acc;
  logic [7:0]  r_result;
  logic        r_zero;
  logic        r_ovf;

  logic [3:0]  w_start_cnt;
  logic [7:0]  w_imm_res;
  logic [15:0] w_acc_nxt;
  logic [7:0]  w_val_nxt;
  logic [7:0]  w_step_res;
  logic        w_step_ovf;

  always_comb begin
    w_start_cnt = 4'd0;
    case (SELECT)
      c_OP_MUL:                     w_start_cnt = 4'd8;
      c_OP_SLL, c_OP_SRL, c_OP_SRA: w_start_cnt = (DATA2 >= 8'd8) ? 4'd8 : DATA2[3:0];
      c_OP_ROR:                     w_start_cnt = {1'b0, DATA2[2:0]};
      default:                      w_start_cnt = 4'd0;
    endcase
  end

  // Zero-step completion: shifts by 0 pass DATA1 through, illegal ops give 0
  always_comb begin
    w_imm_res = DATA1;
    if (SELECT > c_OP_ROR)
      w_imm_res = 8'h00;
  end

  always_comb begin
    w_acc_nxt = r_acc + (r_val[0] ? r_mcand : 16'd0);
    w_val_nxt = r_val;
    case (r_op)
      c_OP_MUL: w_val_nxt = {1'b0, r_val[7:1]};
      c_OP_SLL: w_val_nxt = {r_val[6:0], 1'b0};
      c_OP_SRL: w_val_nxt = {1'b0, r_val[7:1]};
      c_OP_SRA: w_val_nxt = {r_val[7], r_val[7:1]};
      c_OP_ROR: w_val_nxt = {r_val[0], r_val[7:1]};
      default:  w_val_nxt = r_val;
    endcase
    w_step_res = w_val_nxt;
    w_step_ovf = 1'b0;
    if (r_op == c_OP_MUL) begin
      w_step_res = w_acc_nxt[7:0];
      w_step_ovf = |w_acc_nxt[15:8];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= c_IDLE;
      r_op     <= 3'd0;
      r_cnt    <= 4'd0;
      r_val    <= 8'd0;
      r_mcand  <= 16'd0;
      r_acc    <= 16'd0;
      r_result <= 8'h00;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (START) begin
            r_op    <= SELECT;
            r_cnt   <= w_start_cnt;
            r_acc   <= 16'd0;
            r_val   <= (SELECT == c_OP_MUL) ? DATA2 : DATA1;
            r_mcand <= {8'd0, DATA1};
            if (w_start_cnt == 4'd0) begin
              r_result <= w_imm_res;
              r_zero   <= (w_imm_res == 8'h00);
              r_ovf    <= 1'b0;
              r_state  <= c_FIN;
            end else begin
              r_state  <= c_RUN;
            end
          end
        end
        c_RUN: begin
          r_val   <= w_val_nxt;
          r_acc   <= w_acc_nxt;
          r_mcand <= {r_mcand[14:0], 1'b0};
          r_cnt   <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_result <= w_step_res;
            r_zero   <= (w_step_res == 8'h00);
            r_ovf    <= w_step_ovf;
            r_state  <= c_FIN;
          end
        end
        c_FIN:   r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign RESULT = r_result;
  assign ZERO   = r_zero;
  assign OVF    = r_ovf;
  assign BUSY   = (r_state == c_RUN) || (r_state == c_FIN);
  assign DONE   = (r_state == c_FIN);

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_alu
//  Brief    : Directed self-checking bench for seq_alu.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_alu;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] DATA1, DATA2;
  logic [2:0] SELECT;
  logic       START;
  logic [7:0] RESULT;
  logic       BUSY, DONE, ZERO, OVF;

  int errors = 0;
  int checks = 0;

  seq_alu dut (
    .CLK(CLK), .RESET(RESET), .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT),
    .START(START), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE), .ZERO(ZERO), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one op, follow it cycle by cycle, scramble operands while running
  task automatic do_op(input string tag, input logic [2:0] sel, input logic [7:0] a,
                       input logic [7:0] b, input int n, input logic [7:0] exp_res,
                       input logic exp_z, input logic exp_ovf);
    @(negedge CLK);
    SELECT = sel; DATA1 = a; DATA2 = b; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < n; k++) begin
      check({tag, " busy/done run"}, {14'd0, BUSY, DONE}, 16'b10);
      DATA1 = 8'($urandom); DATA2 = 8'($urandom); SELECT = 3'($urandom);
      tick();
    end
    check({tag, " busy/done fin"}, {14'd0, BUSY, DONE}, 16'b11);
    check({tag, " result"}, {8'd0, RESULT}, {8'd0, exp_res});
    check({tag, " zero/ovf"}, {14'd0, ZERO, OVF}, {14'd0, exp_z, exp_ovf});
    tick();
    check({tag, " busy/done idle"}, {14'd0, BUSY, DONE}, 16'b00);
    check({tag, " result held"}, {8'd0, RESULT}, {8'd0, exp_res});
  endtask

  initial begin
    RESET = 1'b0; START = 1'b0; DATA1 = 8'd0; DATA2 = 8'd0; SELECT = 3'd0;
    #12;
    check("reset outputs", {RESULT, 3'd0, ZERO, OVF, BUSY, DONE}, {8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge CLK); RESET = 1'b1;

    do_op("mul 13x11",   3'b000, 8'd13, 8'd11,  8, 8'h8F, 1'b0, 1'b0);
    do_op("mul 20x15",   3'b000, 8'd20, 8'd15,  8, 8'h2C, 1'b0, 1'b1);
    do_op("mul 0xff",    3'b000, 8'd0,  8'hFF,  8, 8'h00, 1'b1, 1'b0);
    do_op("mul ffxff",   3'b000, 8'hFF, 8'hFF,  8, 8'h01, 1'b0, 1'b1);
    do_op("illegal 110", 3'b110, 8'h77, 8'h03,  0, 8'h00, 1'b1, 1'b0);
    do_op("sra 90 by 3", 3'b011, 8'h90, 8'd3,   3, 8'hF2, 1'b0, 1'b0);
    do_op("sra 80 by ff",3'b011, 8'h80, 8'd255, 8, 8'hFF, 1'b0, 1'b0);
    do_op("sll ff by 200",3'b001,8'hFF, 8'd200, 8, 8'h00, 1'b1, 1'b0);
    do_op("sll 5a by 0", 3'b001, 8'h5A, 8'd0,   0, 8'h5A, 1'b0, 1'b0);
    do_op("sll 5a by 2", 3'b001, 8'h5A, 8'd2,   2, 8'h68, 1'b0, 1'b0);
    do_op("srl b4 by 3", 3'b010, 8'hB4, 8'd3,   3, 8'h16, 1'b0, 1'b0);
    do_op("ror 81 by 9", 3'b100, 8'h81, 8'd9,   1, 8'hC0, 1'b0, 1'b0);
    do_op("ror 81 by 4", 3'b100, 8'h81, 8'd4,   4, 8'h18, 1'b0, 1'b0);
    do_op("ror 5a by 8", 3'b100, 8'h5A, 8'd8,   0, 8'h5A, 1'b0, 1'b0);

    // START held high across back-to-back 3-step SRLs
    @(negedge CLK);
    SELECT = 3'b010; DATA1 = 8'hB4; DATA2 = 8'd3; START = 1'b1;
    tick();                                                     // E0
    check("hold E0 busy", {15'd0, BUSY}, 16'd1);
    tick(); tick(); tick();                                     // E3
    check("hold E3 done", {14'd0, BUSY, DONE}, 16'b11);
    tick();                                                     // E4: FIN ends, START ignored
    check("hold E4 idle", {14'd0, BUSY, DONE}, 16'b00);
    tick();                                                     // E5: second op accepted
    check("hold E5 busy", {14'd0, BUSY, DONE}, 16'b10);
    START = 1'b0;
    tick(); tick(); tick();                                     // E8
    check("hold 2nd done", {14'd0, BUSY, DONE}, 16'b11);
    check("hold 2nd result", {8'd0, RESULT}, 16'h0016);
    tick();

    // START pulses during RUN and FIN must not spawn another operation
    @(negedge CLK);
    SELECT = 3'b011; DATA1 = 8'h90; DATA2 = 8'd3; START = 1'b1;
    tick(); START = 1'b0;                                       // E0
    tick();                                                     // E1
    START = 1'b1; tick(); START = 1'b0;                         // E2 (RUN)
    tick();                                                     // E3
    check("pulse done", {14'd0, BUSY, DONE}, 16'b11);
    START = 1'b1; tick(); START = 1'b0;                         // E4 (FIN)
    begin
      int seen = 0;
      for (int k = 0; k < 6; k++) begin
        if (BUSY || DONE) seen++;
        tick();
      end
      check("pulse no extra op", 16'(seen), 16'd0);
    end
    check("pulse result", {8'd0, RESULT}, 16'h00F2);

    // Reset in the middle of a multiply
    @(negedge CLK);
    SELECT = 3'b000; DATA1 = 8'd13; DATA2 = 8'd11; START = 1'b1;
    tick(); START = 1'b0;                                       // E0
    tick(); tick(); tick(); tick();                             // E4
    RESET = 1'b0;
    #1;
    check("abort outputs", {RESULT, 3'd0, ZERO, OVF, BUSY, DONE}, {8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge CLK); RESET = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 10; k++) begin
        if (BUSY || DONE) seen++;
        tick();
      end
      check("abort no done", 16'(seen), 16'd0);
    end
    do_op("after reset mul", 3'b000, 8'd13, 8'd11, 8, 8'h8F, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
